answer_parts: RTL and testbench
===============================

# answer_parts

Contestant answer-capture block of the quiz-buzzer design: arms on a host start button, latches the first of four contestant buzzers, runs a countdown and raises an alarm on timeout or false start, and keeps per-contestant scores adjusted by host true/false judgements. It also scans the 4x4 keypad used to set the answer time limit and multiplexes an 8-digit 7-segment display. It sits between the board I/O and the top-level game controller.

## Interface
- TICK_DIV, 100_000_000: clock cycles per countdown second.
- SCAN_DIV, 100_000: clock cycles per display digit / keypad column step.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reload  in  1  host button: abort round, return to IDLE.
- begining  in  1  host button: arm a round.
- Answer  in  4  contestant buzzers, active-high, bit i = contestant i.
- true  in  1  host judges answer correct.
- false  in  1  host judges answer wrong.
- row  in  4  keypad rows, active-low.
- select1, select2  in  1 each  display mode select, {select1,select2}.
- col  out  4  keypad column drive, one-hot active-low.
- DIG  out  8  digit enables, one-hot active-low, DIG[7] leftmost.
- seg_out  out  8  segments active-low, [6:0]=g..a, [7]=dp (always off).
- getter  out  1  a contestant has been latched this round.
- Answer_led  out  4  one-hot latched winner.
- alarm  out  1  timeout or false start.

## Operation
- All buttons, Answer and row pass through 2-flop synchronizers; reload, begining, true, false use rising-edge detect.
- States: IDLE, ARMED, LOCKED, JUDGED, TIMEOUT.
- reload edge: any state -> IDLE; clears getter, Answer_led, alarm; countdown := time limit.
- begining edge in IDLE -> ARMED. reload and begining edges in the same cycle: reload, then arm (ends ARMED with fresh countdown). begining ignored elsewhere.
- ARMED: any Answer bit set -> latch lowest-index set bit (priority Answer[0]); Answer_led one-hot, getter=1, -> LOCKED; countdown freezes. Countdown decrements every TICK_DIV cycles; reaching 0 -> alarm=1, -> TIMEOUT. Answer and zero-reach in same cycle: answer wins.
- IDLE: any Answer bit set -> alarm=1 (false start), stays IDLE until reload.
- LOCKED: true edge -> winner score +1 (saturate 99), -> JUDGED; false edge -> score -1 (saturate 0), -> JUDGED; both same cycle -> ignored, stay LOCKED.
- JUDGED, TIMEOUT: wait for reload.
- Keypad layout rows 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D. col rotates one step per SCAN_DIV; a key registers once when its row reads low, re-armed only after all rows high for a full column cycle. Keys act only in IDLE: digit d -> limit := (limit mod 10)*10 + d; * -> limit := 0; A -> all scores := 0; others ignored. Limit 0 arms then times out after one tick.
- Display, digit step every SCAN_DIV: mode 00 scores P0..P3 two digits each, left to right; 01 countdown on DIG[1:0], winner number (1-4) on DIG[7], others blank; 10 limit on DIG[1:0]; 11 state code 0-4 on DIG[0]. Values BCD, blank = 8'hFF.

## Timing
- Reset: IDLE, scores 0, limit 30, countdown 30, getter 0, Answer_led 0, alarm 0, col 4'b1110, DIG 8'b1111_1110, seg_out 8'hFF.
- Button edge -> state/output change on the 3rd rising clk after the input changes (2 sync + 1 register).
- Answer high -> getter/Answer_led on 3rd rising edge; unaffected by later Answer changes.
- All outputs registered; seg_out follows DIG by zero cycles (same register update).

## Structure
- Shared package: state encoding, segment patterns for 0-9 and blank, keypad key-code constants.
- One natural sub-module: seg_scan (digit counter, BCD->segment, DIG drive), shared SCAN_DIV tick feeds keypad column.

## Test plan
- TICK_DIV=10, SCAN_DIV=4. Reset, reload+begining together, Answer=4'b0110 -> Answer_led=4'b0010, getter=1, alarm=0.
- Armed, no Answer for 30 ticks -> alarm=1 at countdown 0, getter=0; reload -> alarm=0, countdown 30.
- Answer=4'b0001 in IDLE -> alarm=1; begining ignored until reload.
- LOCKED on contestant 2, true pulse -> score P2=1; next round false twice over two rounds -> P2=0 (saturates).
- Keys 4 then 5 in IDLE, mode 10 -> DIG[1:0] show "45"; arm -> countdown starts at 45.
- true and false same cycle in LOCKED -> no score change, still LOCKED; rst mid-ARMED -> all reset values immediately.

Source files
------------

// File: rtl/answer_parts_pkg.sv
`default_nettype none
// ============================================================================
// answer_parts_pkg : round states, 7-segment patterns, keypad codes, helpers
// Revision 1.0 - initial release
// ============================================================================
package answer_parts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_JUDGED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [6:0] LIMIT_RESET = 7'd30;
  localparam logic [6:0] SCORE_MAX   = 7'd99;
  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Active-low segments {dp, g..a}; dp is never lit.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  // Layout rows 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'd1;
      4'h1:    k = 4'd2;
      4'h2:    k = 4'd3;
      4'h3:    k = KEY_A;
      4'h4:    k = 4'd4;
      4'h5:    k = 4'd5;
      4'h6:    k = 4'd6;
      4'h7:    k = KEY_B;
      4'h8:    k = 4'd7;
      4'h9:    k = 4'd8;
      4'hA:    k = 4'd9;
      4'hB:    k = KEY_C;
      4'hC:    k = KEY_STAR;
      4'hD:    k = 4'd0;
      4'hE:    k = KEY_HASH;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/answer_parts_seg_scan.sv
`default_nettype none
// ============================================================================
// answer_parts_seg_scan : scan divider, 8-digit 7-seg multiplexer, keypad column drive
// Revision 1.0 - initial release
// ============================================================================
module answer_parts_seg_scan
  import answer_parts_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  output logic        scan_tick,
  output logic [1:0]  col_idx,
  output logic [3:0]  col,
  output logic [7:0]  DIG,
  output logic [7:0]  seg_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [3:0]    col_q, col_d;
  logic [7:0]    dig_q, dig_d;
  logic [7:0]    seg_q, seg_d;

  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign col_idx   = dig_idx_q[1:0];
  assign col       = col_q;
  assign DIG       = dig_q;
  assign seg_out   = seg_q;

  // Segments are looked up from the next digit index so DIG and seg_out change together.
  always_comb begin
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    dig_idx_d  = scan_tick ? dig_idx_q + 3'd1 : dig_idx_q;
    dig_d      = ~(8'd1 << dig_idx_d);
    col_d      = ~(4'd1 << dig_idx_d[1:0]);
    seg_d      = bcd_to_seg(digits[{dig_idx_d, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= 3'd0;
      col_q      <= 4'b1110;
      dig_q      <= 8'b1111_1110;
      seg_q      <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      col_q      <= col_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/answer_parts.sv
`default_nettype none
// ============================================================================
// answer_parts : quiz answer capture, countdown, scoring, keypad limit entry, display
// Revision 1.0 - initial release
// ============================================================================
module answer_parts
  import answer_parts_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic       begining,
  input  logic [3:0] Answer,
  input  logic       true,
  input  logic       false,
  input  logic [3:0] row,
  input  logic       select1,
  input  logic       select2,
  output logic [3:0] col,
  output logic [7:0] DIG,
  output logic [7:0] seg_out,
  output logic       getter,
  output logic [3:0] Answer_led,
  output logic       alarm
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [3:0] ans_s1_q, ans_s2_q, row_s1_q, row_s2_q;
  logic [3:0] btn_s1_q, btn_s2_q, btn_prev_q;
  logic [1:0] sel_s1_q, sel_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ans_s1_q   <= '0;
      ans_s2_q   <= '0;
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
    end else begin
      ans_s1_q   <= Answer;
      ans_s2_q   <= ans_s1_q;
      row_s1_q   <= row;
      row_s2_q   <= row_s1_q;
      btn_s1_q   <= {false, true, begining, reload};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      sel_s1_q   <= {select1, select2};
      sel_s2_q   <= sel_s1_q;
    end
  end

  logic [3:0] btn_rise;
  logic       reload_e, begin_e, true_e, false_e;
  assign btn_rise = btn_s2_q & ~btn_prev_q;
  assign reload_e = btn_rise[0];
  assign begin_e  = btn_rise[1];
  assign true_e   = btn_rise[2];
  assign false_e  = btn_rise[3];

  state_e        state_q, state_d;
  logic [1:0]    winner_q, winner_d;
  logic          getter_q, getter_d;
  logic [3:0]    led_q, led_d;
  logic          alarm_q, alarm_d;
  logic [6:0]    countdown_q, countdown_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [6:0]    limit_q, limit_d;
  logic [3:0][6:0] scores_q, scores_d;
  logic          key_armed_q, key_armed_d;
  logic [1:0]    quiet_cnt_q, quiet_cnt_d;

  logic        scan_tick;
  logic [1:0]  col_idx;
  logic        key_hit;
  logic [3:0]  key;
  logic [31:0] digits;

  assign getter     = getter_q;
  assign Answer_led = led_q;
  assign alarm      = alarm_q;

  // A key fires once; it re-arms only after four consecutive all-high column samples.
  assign key_hit = scan_tick && key_armed_q && (row_s2_q != 4'hF);
  assign key     = key_code(lowest_set(~row_s2_q), col_idx);

  always_comb begin
    key_armed_d = key_armed_q;
    quiet_cnt_d = quiet_cnt_q;
    if (scan_tick) begin
      if (row_s2_q != 4'hF) begin
        key_armed_d = 1'b0;
        quiet_cnt_d = 2'd0;
      end else if (!key_armed_q) begin
        if (quiet_cnt_q == 2'd3) begin
          key_armed_d = 1'b1;
          quiet_cnt_d = 2'd0;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    getter_d    = getter_q;
    led_d       = led_q;
    alarm_d     = alarm_q;
    countdown_d = countdown_q;
    tick_cnt_d  = tick_cnt_q;
    limit_d     = limit_q;
    scores_d    = scores_q;

    if (reload_e) begin
      state_d     = begin_e ? ST_ARMED : ST_IDLE;
      getter_d    = 1'b0;
      led_d       = 4'b0;
      alarm_d     = 1'b0;
      countdown_d = limit_q;
      tick_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ans_s2_q != 4'b0) begin
            alarm_d = 1'b1;
          end else if (begin_e && !alarm_q) begin
            state_d     = ST_ARMED;
            countdown_d = limit_q;
            tick_cnt_d  = '0;
          end
        end
        ST_ARMED: begin
          if (ans_s2_q != 4'b0) begin
            winner_d = lowest_set(ans_s2_q);
            led_d    = 4'd1 << lowest_set(ans_s2_q);
            getter_d = 1'b1;
            state_d  = ST_LOCKED;
          end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            // A limit of 0 still waits one full tick before timing out.
            if (countdown_q <= 7'd1) begin
              countdown_d = 7'd0;
              alarm_d     = 1'b1;
              state_d     = ST_TIMEOUT;
            end else begin
              countdown_d = countdown_q - 7'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (true_e != false_e) begin
            state_d = ST_JUDGED;
            if (true_e) begin
              if (scores_q[winner_q] != SCORE_MAX)
                scores_d[winner_q] = scores_q[winner_q] + 7'd1;
            end else if (scores_q[winner_q] != 7'd0) begin
              scores_d[winner_q] = scores_q[winner_q] - 7'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (key_hit && (state_q == ST_IDLE)) begin
      if (key <= 4'd9)
        limit_d = 7'((limit_q % 7'd10) * 7'd10 + {3'b000, key});
      else if (key == KEY_STAR)
        limit_d = 7'd0;
      else if (key == KEY_A)
        scores_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= 2'd0;
      getter_q    <= 1'b0;
      led_q       <= 4'b0;
      alarm_q     <= 1'b0;
      countdown_q <= LIMIT_RESET;
      tick_cnt_q  <= '0;
      limit_q     <= LIMIT_RESET;
      scores_q    <= '0;
      key_armed_q <= 1'b1;
      quiet_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      getter_q    <= getter_d;
      led_q       <= led_d;
      alarm_q     <= alarm_d;
      countdown_q <= countdown_d;
      tick_cnt_q  <= tick_cnt_d;
      limit_q     <= limit_d;
      scores_q    <= scores_d;
      key_armed_q <= key_armed_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

  // Nibble k of digits drives DIG[k]; DIG[7] is the leftmost digit.
  always_comb begin
    digits = {8{BCD_BLANK}};
    case (sel_s2_q)
      2'b00: digits = {to_bcd2(scores_q[0]), to_bcd2(scores_q[1]),
                       to_bcd2(scores_q[2]), to_bcd2(scores_q[3])};
      2'b01: begin
        digits[7:0]   = to_bcd2(countdown_q);
        digits[31:28] = getter_q ? ({2'b00, winner_q} + 4'd1) : BCD_BLANK;
      end
      2'b10:   digits[7:0] = to_bcd2(limit_q);
      default: digits[3:0] = {1'b0, state_q};
    endcase
  end

  answer_parts_seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .scan_tick (scan_tick),
    .col_idx   (col_idx),
    .col       (col),
    .DIG       (DIG),
    .seg_out   (seg_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_answer_parts.sv
`default_nettype none
// ============================================================================
// tb_answer_parts : directed self-checking bench for answer_parts
// Revision 1.0 - initial release
// ============================================================================
module tb_answer_parts;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;       // {false, true, begining, reload}
  logic [3:0] ans = 4'b0;
  logic [1:0] sel = 2'b00;      // {select1, select2}
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] DIG;
  logic [7:0] seg_out;
  logic       getter;
  logic [3:0] Answer_led;
  logic       alarm;

  logic       key_on = 1'b0;
  logic [1:0] key_r  = 2'd0;
  logic [1:0] key_c  = 2'd0;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  // Keypad matrix: the held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    if (key_on && (col[key_c] == 1'b0)) row[key_r] = 1'b0;
  end

  answer_parts #(
    .TICK_DIV (10),
    .SCAN_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reload     (btn[0]),
    .begining   (btn[1]),
    .Answer     (ans),
    .true       (btn[2]),
    .false      (btn[3]),
    .row        (row),
    .select1    (sel[1]),
    .select2    (sel[0]),
    .col        (col),
    .DIG        (DIG),
    .seg_out    (seg_out),
    .getter     (getter),
    .Answer_led (Answer_led),
    .alarm      (alarm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(3);
    btn[b] = 1'b0;
    cyc(3);
  endtask

  task automatic set_mode(input logic [1:0] m);
    sel = m;
    cyc(4);
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
    cyc(40);
    key_on = 1'b0;
    cyc(40);
  endtask

  task automatic chk_dig(input string tag, input int k, input logic [7:0] exp);
    logic [7:0] target;
    int w;
    target = ~(8'd1 << k);
    w = 0;
    while (DIG !== target && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      total++;
      bad++;
      $error("FAIL %s_wait: DIG observed=%0h expected=%0h", tag, DIG, target);
    end else begin
      chk(tag, {24'b0, seg_out}, {24'b0, exp});
    end
  endtask

  task automatic wait_alarm(output int cnt);
    cnt = 0;
    while (alarm !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_getter", getter, 1'b0);
    chk("rst_led", Answer_led, 4'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_col", col, 4'b1110);
    chk("rst_dig", DIG, 8'b1111_1110);
    chk("rst_seg", seg_out, 8'hFF);
    rst = 1'b0;
    cyc(2);
    set_mode(2'b10);
    chk_dig("rst_limit_tens", 1, 8'hB0);
    chk_dig("rst_limit_ones", 0, 8'hC0);

    // reload and begining together arm the round; lowest buzzer wins
    btn = 4'b0011;
    cyc(3);
    btn = 4'b0000;
    cyc(3);
    ans = 4'b0110;
    cyc(3);
    chk("win1_led", Answer_led, 4'b0010);
    chk("win1_getter", getter, 1'b1);
    chk("win1_alarm", alarm, 1'b0);
    ans = 4'b0001;
    cyc(3);
    chk("win1_led_hold", Answer_led, 4'b0010);
    ans = 4'b0000;
    set_mode(2'b01);
    chk_dig("win1_number", 7, 8'hA4);
    chk_dig("win1_cd_tens", 1, 8'hB0);

    // timeout after 30 ticks of 10 cycles
    press(0);
    chk("rl_getter", getter, 1'b0);
    chk("rl_led", Answer_led, 4'b0);
    set_mode(2'b11);
    chk_dig("state_idle", 0, 8'hC0);
    press(1);
    wait_alarm(n);
    chk("timeout30_cycles", n, 297);
    chk("timeout_getter", getter, 1'b0);
    chk_dig("state_timeout", 0, 8'h99);
    set_mode(2'b01);
    chk_dig("cd_zero_ones", 0, 8'hC0);
    chk_dig("cd_zero_tens", 1, 8'hC0);
    chk_dig("no_winner", 7, 8'hFF);
    press(0);
    chk("rl_alarm", alarm, 1'b0);
    chk_dig("cd_reload_tens", 1, 8'hB0);
    chk_dig("cd_reload_ones", 0, 8'hC0);

    // false start in IDLE blocks arming until reload
    ans = 4'b0001;
    cyc(3);
    chk("fs_alarm", alarm, 1'b1);
    ans = 4'b0000;
    press(1);
    set_mode(2'b11);
    chk_dig("fs_state_idle", 0, 8'hC0);
    chk("fs_getter", getter, 1'b0);
    press(0);
    chk("fs_cleared", alarm, 1'b0);

    // contestant 2 scoring
    press(1);
    ans = 4'b0100;
    cyc(3);
    chk("win2_led", Answer_led, 4'b0100);
    ans = 4'b0000;
    press(2);
    set_mode(2'b00);
    chk_dig("p2_true_ones", 2, 8'hF9);
    chk_dig("p2_true_tens", 3, 8'hC0);
    chk_dig("p1_untouched", 4, 8'hC0);
    set_mode(2'b11);
    chk_dig("state_judged", 0, 8'hB0);

    press(0);
    press(1);
    ans = 4'b0100;
    cyc(3);
    ans = 4'b0000;
    btn = 4'b1100;
    cyc(3);
    btn = 4'b0000;
    cyc(3);
    chk_dig("both_still_locked", 0, 8'hA4);
    set_mode(2'b00);
    chk_dig("both_p2_kept", 2, 8'hF9);
    press(3);
    chk_dig("p2_false", 2, 8'hC0);

    press(0);
    press(1);
    ans = 4'b0100;
    cyc(3);
    ans = 4'b0000;
    press(3);
    chk_dig("p2_sat_ones", 2, 8'hC0);
    chk_dig("p2_sat_tens", 3, 8'hC0);
    set_mode(2'b11);
    chk_dig("state_judged2", 0, 8'hB0);

    // keypad limit entry 4, 5 -> 45
    press(0);
    press_key(2'd1, 2'd0);
    press_key(2'd1, 2'd1);
    set_mode(2'b10);
    chk_dig("lim45_tens", 1, 8'h99);
    chk_dig("lim45_ones", 0, 8'h92);
    press(1);
    wait_alarm(n);
    chk("timeout45_cycles", n, 447);

    // asynchronous reset while armed
    press(0);
    press(1);
    cyc(5);
    rst = 1'b1;
    #1;
    chk("rst2_alarm", alarm, 1'b0);
    chk("rst2_led", Answer_led, 4'b0);
    chk("rst2_col", col, 4'b1110);
    chk("rst2_dig", DIG, 8'b1111_1110);
    chk("rst2_seg", seg_out, 8'hFF);
    cyc(2);
    rst = 1'b0;
    set_mode(2'b11);
    chk_dig("rst2_state", 0, 8'hC0);
    set_mode(2'b10);
    chk_dig("rst2_limit_tens", 1, 8'hB0);

    // '*' clears the limit; a zero limit times out after one tick
    press_key(2'd3, 2'd0);
    chk_dig("lim0_tens", 1, 8'hC0);
    chk_dig("lim0_ones", 0, 8'hC0);
    press(1);
    wait_alarm(n);
    chk("timeout0_cycles", n, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
